screen_write_ctrl: RTL and testbench

// - Sequences every write into the 80x25 character buffer, driving its din, waddr, wen and scroll inputs.
// - Sits between the VT52 command decoder and the character buffer.
// - Owns the cursor (row/col) and executes these commands: put-char, CR, LF, home, erase-EOL, erase-EOS, set-row, set-col.
// - LF on the last row requests a buffer scroll, then holds off all writes until the buffer reports scroll_done.

---
 rtl/vt52_pkg.sv | 33 +++
 rtl/cursor_addr_gen.sv | 105 ++++++++++
 rtl/screen_write_ctrl.sv | 175 +++++++++++++++++
 tb/tb_screen_write_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vt52_pkg.sv
// ============================================================================
// Module      : vt52_pkg
// Description : Shared opcodes, FSM state encoding and screen geometry for
//               the VT52 screen write path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package vt52_pkg;

    localparam logic [2:0] CMD_PUT       = 3'd0;
    localparam logic [2:0] CMD_CR        = 3'd1;
    localparam logic [2:0] CMD_LF        = 3'd2;
    localparam logic [2:0] CMD_HOME      = 3'd3;
    localparam logic [2:0] CMD_ERASE_EOL = 3'd4;
    localparam logic [2:0] CMD_ERASE_EOS = 3'd5;
    localparam logic [2:0] CMD_SET_ROW   = 3'd6;
    localparam logic [2:0] CMD_SET_COL   = 3'd7;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_WRITE       = 3'd1;
    localparam logic [2:0] ST_ERASE       = 3'd2;
    localparam logic [2:0] ST_SCROLL_REQ  = 3'd3;
    localparam logic [2:0] ST_SCROLL_WAIT = 3'd4;

    localparam logic [7:0] SPACE = 8'h20;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 25;

endpackage

`default_nettype wire

// File: rtl/cursor_addr_gen.sv
// ============================================================================
// Module      : cursor_addr_gen
// Description : Cursor row/col, row base address (row*COLS) and linear erase
//               pointer for the screen write controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cursor_addr_gen
    import vt52_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 col_inc,
    input  logic                 col_clr,
    input  logic                 row_inc,
    input  logic                 home,
    input  logic                 set_row,
    input  logic                 set_col,
    input  logic [7:0]           set_val,
    input  logic                 ptr_load,
    input  logic                 ptr_inc,
    output logic [ROW_BITS-1:0]  row,
    output logic [COL_BITS-1:0]  col,
    output logic [ADDR_BITS-1:0] cur_addr,
    output logic [ADDR_BITS-1:0] row_end,
    output logic [ADDR_BITS-1:0] ptr
);

    localparam logic [ROW_BITS-1:0]  ROW_MAX  = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0]  COL_MAX  = COL_BITS'(COLS - 1);
    localparam logic [7:0]           ROW_MAX8 = 8'(ROWS - 1);
    localparam logic [7:0]           COL_MAX8 = 8'(COLS - 1);
    localparam logic [ADDR_BITS-1:0] COLS_A   = ADDR_BITS'(COLS);

    logic [ROW_BITS-1:0]  row_q, row_d, set_row_val;
    logic [COL_BITS-1:0]  col_q, col_d, set_col_val;
    logic [ADDR_BITS-1:0] row_base_q, row_base_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;

    assign row      = row_q;
    assign col      = col_q;
    assign ptr      = ptr_q;
    assign cur_addr = row_base_q + ADDR_BITS'(col_q);
    assign row_end  = row_base_q + (COLS_A - 1'b1);

    always_comb begin
        set_row_val = (set_val > ROW_MAX8) ? ROW_MAX : ROW_BITS'(set_val);
        set_col_val = (set_val > COL_MAX8) ? COL_MAX : COL_BITS'(set_val);
        row_d       = row_q;
        col_d       = col_q;
        row_base_d  = row_base_q;
        ptr_d       = ptr_q;

        if (home) begin
            row_d      = '0;
            col_d      = '0;
            row_base_d = '0;
        end else begin
            // Column saturates at the right edge: no autowrap.
            if (col_clr)
                col_d = '0;
            else if (set_col)
                col_d = set_col_val;
            else if (col_inc && col_q != COL_MAX)
                col_d = col_q + 1'b1;

            if (set_row) begin
                row_d      = set_row_val;
                row_base_d = ADDR_BITS'(set_row_val) * COLS_A;
            end else if (row_inc && row_q != ROW_MAX) begin
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + COLS_A;
            end
        end

        if (ptr_load)
            ptr_d = cur_addr;
        else if (ptr_inc)
            ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            ptr_q      <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/screen_write_ctrl.sv
// ============================================================================
// Module      : screen_write_ctrl
// Description : Executes VT52 cursor/write commands and sequences all writes
//               and scroll requests into the 80x25 character buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module screen_write_ctrl
    import vt52_pkg::*;
#(
    parameter int ADDR_BITS = 11,
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int ROW_BITS  = 5,
    parameter int COL_BITS  = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [7:0]           cmd_data,
    output logic [7:0]           buf_din,
    output logic [ADDR_BITS-1:0] buf_waddr,
    output logic                 buf_wen,
    output logic                 buf_scroll,
    input  logic                 buf_scroll_busy,
    input  logic                 buf_scroll_done,
    output logic [ROW_BITS-1:0]  cursor_row,
    output logic [COL_BITS-1:0]  cursor_col,
    output logic                 busy
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(ROWS * COLS - 1);
    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);

    logic [2:0] state_q, state_d;
    logic       hold_q, hold_d;
    logic [7:0] char_q, char_d;
    logic       eos_q, eos_d;

    logic accept;
    logic col_inc, col_clr, row_inc, home, set_row, set_col, ptr_load, ptr_inc;
    logic [ADDR_BITS-1:0] cur_addr, row_end, ptr, erase_end;

    // hold_q masks ready for the cycle after any accept, so one-cycle
    // commands that stay in IDLE still show a ready gap.
    assign cmd_ready = (state_q == ST_IDLE) && !hold_q;
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign erase_end = eos_q ? LAST_ADDR : row_end;

    always_comb begin
        state_d    = state_q;
        hold_d     = accept;
        char_d     = char_q;
        eos_d      = eos_q;
        col_inc    = 1'b0;
        col_clr    = 1'b0;
        row_inc    = 1'b0;
        home       = 1'b0;
        set_row    = 1'b0;
        set_col    = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        buf_wen    = 1'b0;
        buf_din    = 8'h00;
        buf_waddr  = '0;
        buf_scroll = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        CMD_PUT: begin
                            char_d  = cmd_data;
                            state_d = ST_WRITE;
                        end
                        CMD_CR:   col_clr = 1'b1;
                        CMD_LF: begin
                            if (cursor_row == LAST_ROW)
                                state_d = ST_SCROLL_REQ;
                            else
                                row_inc = 1'b1;
                        end
                        CMD_HOME: home = 1'b1;
                        CMD_ERASE_EOL: begin
                            ptr_load = 1'b1;
                            eos_d    = 1'b0;
                            state_d  = ST_ERASE;
                        end
                        CMD_ERASE_EOS: begin
                            ptr_load = 1'b1;
                            eos_d    = 1'b1;
                            state_d  = ST_ERASE;
                        end
                        CMD_SET_ROW: set_row = 1'b1;
                        default:     set_col = 1'b1;
                    endcase
                end
            end
            ST_WRITE: begin
                buf_wen   = 1'b1;
                buf_din   = char_q;
                buf_waddr = cur_addr;
                col_inc   = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERASE: begin
                buf_wen   = 1'b1;
                buf_din   = SPACE;
                buf_waddr = ptr;
                if (ptr == erase_end)
                    state_d = ST_IDLE;
                else
                    ptr_inc = 1'b1;
            end
            ST_SCROLL_REQ: begin
                // Never stack a request onto a scroll the buffer already owns.
                if (!buf_scroll_busy) begin
                    buf_scroll = 1'b1;
                    state_d    = ST_SCROLL_WAIT;
                end
            end
            ST_SCROLL_WAIT: begin
                if (buf_scroll_done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b0;
            char_q  <= 8'h00;
            eos_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            char_q  <= char_d;
            eos_q   <= eos_d;
        end
    end

    cursor_addr_gen #(
        .ADDR_BITS (ADDR_BITS),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ROW_BITS  (ROW_BITS),
        .COL_BITS  (COL_BITS)
    ) u_cursor (
        .clk      (clk),
        .reset_n  (reset_n),
        .col_inc  (col_inc),
        .col_clr  (col_clr),
        .row_inc  (row_inc),
        .home     (home),
        .set_row  (set_row),
        .set_col  (set_col),
        .set_val  (cmd_data),
        .ptr_load (ptr_load),
        .ptr_inc  (ptr_inc),
        .row      (cursor_row),
        .col      (cursor_col),
        .cur_addr (cur_addr),
        .row_end  (row_end),
        .ptr      (ptr)
    );

endmodule

`default_nettype wire

// File: tb/tb_screen_write_ctrl.sv
// ============================================================================
// Module      : tb_screen_write_ctrl
// Description : Directed self-checking bench for screen_write_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_screen_write_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [7:0]  buf_din;
    logic [10:0] buf_waddr;
    logic        buf_wen;
    logic        buf_scroll;
    logic        buf_scroll_busy;
    logic        buf_scroll_done;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    screen_write_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .buf_din         (buf_din),
        .buf_waddr       (buf_waddr),
        .buf_wen         (buf_wen),
        .buf_scroll      (buf_scroll),
        .buf_scroll_busy (buf_scroll_busy),
        .buf_scroll_done (buf_scroll_done),
        .cursor_row      (cursor_row),
        .cursor_col      (cursor_col),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] data);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    // One-cycle command: ready low for exactly one cycle, then back.
    task automatic issue1(input string tag, input logic [2:0] op, input logic [7:0] data);
        issue(op, data);
        check({tag, "_ready_low"}, cmd_ready, 0);
        tick();
        check({tag, "_ready_back"}, cmd_ready, 1);
    endtask

    task automatic put(input logic [7:0] ch, input logic [10:0] addr);
        issue(3'd0, ch);
        check("put_wen", buf_wen, 1);
        check("put_addr", buf_waddr, addr);
        check("put_din", buf_din, ch);
        check("put_ready_low", cmd_ready, 0);
        tick();
        check("put_wen_drop", buf_wen, 0);
        check("put_ready_back", cmd_ready, 1);
    endtask

    task automatic erase_run(input string tag, input logic [2:0] op, input int first, input int count);
        int n;
        issue(op, 8'h00);
        n = 0;
        while (busy && n < 3000) begin
            check({tag, "_wen"}, buf_wen, 1);
            check({tag, "_addr"}, buf_waddr, first + n);
            check({tag, "_din"}, buf_din, 8'h20);
            n++;
            tick();
        end
        check({tag, "_count"}, n, count);
        check({tag, "_wen_after"}, buf_wen, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wen;
        int n_scr;

        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_op          = 3'd0;
        cmd_data        = 8'h00;
        buf_scroll_busy = 1'b0;
        buf_scroll_done = 1'b0;
        repeat (3) tick();
        check("rst_wen", buf_wen, 0);
        check("rst_busy", busy, 0);
        check("rst_scroll", buf_scroll, 0);
        #3 reset_n = 1'b1;
        tick();
        check("rst_ready", cmd_ready, 1);
        check("rst_row", cursor_row, 0);
        check("rst_col", cursor_col, 0);
        check("rst_din", buf_din, 0);
        check("rst_addr", buf_waddr, 0);

        // PUT 'A' at origin
        put(8'h41, 11'd0);
        check("putA_col", cursor_col, 1);
        check("putA_row", cursor_row, 0);

        // Right-edge saturation and clamping
        issue1("setrow3", 3'd6, 8'd3);
        check("setrow3_row", cursor_row, 3);
        issue1("setcol79", 3'd7, 8'd79);
        check("setcol79_col", cursor_col, 79);
        put(8'h58, 11'd319);
        check("putX1_col", cursor_col, 79);
        put(8'h58, 11'd319);
        check("putX2_col", cursor_col, 79);
        issue1("setcol10", 3'd7, 8'd10);
        check("setcol10_col", cursor_col, 10);
        issue1("setcol200", 3'd7, 8'd200);
        check("setcol200_clamp", cursor_col, 79);
        issue1("setrow200", 3'd6, 8'd200);
        check("setrow200_clamp", cursor_row, 24);

        // LF on last row with free buffer, long scroll
        issue(3'd2, 8'h00);
        check("lf_scroll_pulse", buf_scroll, 1);
        check("lf_busy", busy, 1);
        check("lf_wen", buf_wen, 0);
        tick();
        check("lf_scroll_once", buf_scroll, 0);
        n_wen = 0;
        n_scr = 0;
        repeat (2000) begin
            if (buf_wen) n_wen++;
            if (buf_scroll) n_scr++;
            tick();
        end
        check("lf_wait_no_wen", n_wen, 0);
        check("lf_wait_no_scroll", n_scr, 0);
        check("lf_wait_busy", busy, 1);
        check("lf_wait_ready", cmd_ready, 0);
        buf_scroll_done = 1'b1;
        #1;
        check("lf_done_cycle_busy", busy, 1);
        tick();
        buf_scroll_done = 1'b0;
        check("lf_idle_after_done", busy, 0);
        check("lf_ready_after_done", cmd_ready, 1);
        check("lf_row_kept", cursor_row, 24);
        check("lf_col_kept", cursor_col, 79);

        // LF while buffer already busy; stray done is ignored
        buf_scroll_busy = 1'b1;
        issue(3'd2, 8'h00);
        check("lfb_no_pulse", buf_scroll, 0);
        buf_scroll_done = 1'b1;
        tick();
        buf_scroll_done = 1'b0;
        check("lfb_stray_done_busy", busy, 1);
        check("lfb_stray_done_scroll", buf_scroll, 0);
        repeat (3) tick();
        check("lfb_still_held", buf_scroll, 0);
        buf_scroll_busy = 1'b0;
        #1;
        check("lfb_pulse_on_release", buf_scroll, 1);
        tick();
        check("lfb_pulse_one", buf_scroll, 0);
        check("lfb_waiting", busy, 1);
        buf_scroll_done = 1'b1;
        tick();
        buf_scroll_done = 1'b0;
        check("lfb_idle", busy, 0);

        // ERASE_EOL from (2,75)
        issue1("setrow2", 3'd6, 8'd2);
        issue1("setcol75", 3'd7, 8'd75);
        erase_run("eol", 3'd4, 235, 5);
        check("eol_row", cursor_row, 2);
        check("eol_col", cursor_col, 75);
        check("eol_ready", cmd_ready, 1);

        // ERASE_EOS from (24,0), then HOME / CR / LF
        issue1("setrow24", 3'd6, 8'd24);
        issue1("cr", 3'd1, 8'h00);
        check("cr_col", cursor_col, 0);
        erase_run("eos", 3'd5, 1920, 80);
        check("eos_row", cursor_row, 24);
        check("eos_col", cursor_col, 0);
        issue1("setcol5", 3'd7, 8'd5);
        issue1("home", 3'd3, 8'h00);
        check("home_row", cursor_row, 0);
        check("home_col", cursor_col, 0);
        issue1("setcol7", 3'd7, 8'd7);
        issue1("cr2", 3'd1, 8'h00);
        check("cr2_col", cursor_col, 0);
        issue1("lf_row", 3'd2, 8'h00);
        check("lf_row1", cursor_row, 1);
        check("lf_row_no_scroll", buf_scroll, 0);

        // Reset in the middle of ERASE_EOS from (5,10)
        issue1("setrow5", 3'd6, 8'd5);
        issue1("setcol10b", 3'd7, 8'd10);
        issue(3'd5, 8'h00);
        repeat (10) tick();
        check("mid_eos_wen", buf_wen, 1);
        check("mid_eos_addr", buf_waddr, 420);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_wen", buf_wen, 0);
        check("async_rst_busy", busy, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_row", cursor_row, 0);
        check("post_rst_col", cursor_col, 0);
        check("post_rst_wen", buf_wen, 0);
        repeat (3) tick();
        check("post_rst_no_resume", buf_wen, 0);
        put(8'h5A, 11'd0);
        check("post_rst_put_col", cursor_col, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
